uart_rx_oversampler: RTL

- Serial front end that turns the raw asynchronous i_Rx pin into the byte/strobe pair consumed by the UART receive buffer: dout[7:0] plus a one-cycle rx_done_tick.
- Synchronises the pin, generates a 16x oversampling tick, validates the start bit, samples mid-bit and checks the stop bit.
- Sits between the board Rx pin and the UART's receive buffer write port (wr <- rx_done_tick, w_data <- dout).

---
 rtl/uart_rx_oversampler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampler.sv
`timescale 1ns/1ps
// UART receive front end: 2-flop pin synchroniser, 16x oversampling tick, mid-bit sampling FSM.
// Outputs are registered one-cycle pulses; optional even parity bit enabled by `define UART_RX_PARITY_EN.
module uart_rx_oversampler #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_Rx,
    output logic [7:0] dout,
    output logic       Rx_done_tick,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [4:0]    SB_LAST  = 5'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST   = 3'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic          sync1_q;
    logic          rx_s_q;
    logic          prev_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          tick;
    state_t        state_q;
    logic [4:0]    s_q;
    logic [2:0]    n_q;
    logic [7:0]    b_q;
    logic [7:0]    b_aligned;
    logic [7:0]    dout_q;
    logic          done_q;
    logic          ferr_q;

    // Synchroniser presets to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_Rx;
            rx_s_q  <= sync1_q;
            prev_q  <= rx_s_q;
        end
    end

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Data arrives LSB first into the MSB, so a short word sits in the top DBIT bits.
    assign b_aligned = b_q >> (8 - DBIT);

`ifdef UART_RX_PARITY_EN
    logic par_pend_q;
    logic perr_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            b_q        <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_pend_q <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (prev_q && !rx_s_q) begin
                        state_q <= START;
                        s_q     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_q == 5'd7) begin
                            if (!rx_s_q) begin
                                state_q <= DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_q == 5'd15) begin
                            b_q <= {rx_s_q, b_q[7:1]};
                            s_q <= '0;
                            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end else begin
                                n_q <= n_q + 3'd1;
                            end
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (s_q == 5'd15) begin
                            par_pend_q <= (rx_s_q != ^b_aligned);
                            s_q        <= '0;
                            state_q    <= STOP;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (s_q == SB_LAST) begin
                            dout_q  <= b_aligned;
                            done_q  <= rx_s_q;
                            ferr_q  <= !rx_s_q;
`ifdef UART_RX_PARITY_EN
                            perr_q     <= par_pend_q;
                            par_pend_q <= 1'b0;
`endif
                            state_q <= IDLE;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout         = dout_q;
    assign Rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule
